// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Single-outstanding APB3 initiator bridging a valid/ready request
//            channel to APB SETUP/ACCESS transfers and back to a response
//            channel. Optional ACCESS-phase timeout: APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    input  logic                      req_write,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [APB_ADDR_WIDTH-1:0] C_ADDR_MASK = ~APB_ADDR_WIDTH'(3);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                      state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [31:0]                 pwdata_q, pwdata_d;
    logic                        pwrite_q, pwrite_d;
    logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
    logic                        rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]                 cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr & C_ADDR_MASK;
                    pwdata_d = req_wdata;
                    pwrite_d = req_write;
                    state_d  = ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = ST_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // The wait that would bring the count to TIMEOUT_CYCLES abandons the transfer
                else if (cnt_q == C_TIMEOUT_LAST) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Handshake and phase strobes decode from the registered state only
    assign req_ready = (state_q == ST_IDLE);
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign rsp_valid = (state_q == ST_RESP);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
